v_lane_sequencer: RTL and testbench
===================================

# v_lane_sequencer

Executes one element-wise vector operation by streaming a source vector pair through the banked vector register files, one row of `lanes_p` elements per cycle. Drives read addresses to the two source register files, computes per lane, and writes results to the destination register file one cycle later. Sits directly upstream of, and downstream of, the banked vector register instances, between the vector issue logic and the register files.

## Interface
- `vlen_p`, 8, elements per vector.
- `vdw_p`, 32, bits per element.
- `lanes_p`, 4, lanes; `vlen_p % lanes_p == 0`.
- `vregs_p`, 8, vector registers addressable by select fields.
- Derived: `addr_width_lp = clog2(vlen_p)`, `rows_lp = vlen_p/lanes_p`, `vl_width_lp = clog2(vlen_p+1)`, `sel_width_lp = clog2(vregs_p)`.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `reset_i`  in  1  synchronous, active-high reset.
- `v_i`  in  1  op request valid.
- `ready_o`  out  1  sequencer idle, can accept.
- `op_i`  in  3  `v_op_e` opcode.
- `vs1_i`, `vs2_i`, `vd_i`  in  `sel_width_lp` each  register selects.
- `vl_i`  in  `vl_width_lp`  active element count, 0..`vlen_p`.
- `rs1_sel_o`, `rs2_sel_o`, `wd_sel_o`  out  `sel_width_lp`  latched selects, steering register-file muxing.
- `ra_addr_o`, `rb_addr_o`  out  `lanes_p` x `addr_width_lp`  per-lane read element index.
- `ra_data_i`, `rb_data_i`  in  `lanes_p` x `vdw_p`  per-lane read data, combinational from the address.
- `w_addr_o`  out  `lanes_p` x `addr_width_lp`  per-lane write element index.
- `w_data_o`  out  `lanes_p` x `vdw_p`  write data.
- `w_en_o`  out  `lanes_p`  per-lane write enable.
- `done_o`  out  1  one-cycle pulse with final write cycle.

## Operation
- Element mapping: lane `i`, row `r` maps to element index `r*lanes_p + i`. Both read and write addresses use this index.
- FSM states:
  - IDLE: `ready_o=1`; on `v_i & ready_o`, latch op, selects, and `vl`; clear row counter; go to RUN.
  - RUN: drive row-counter addresses; register ALU results, row, and masked enables into the write stage; increment the row counter. After row `rows_lp-1`, go to DRAIN.
  - DRAIN: write stage retires the last row; `done_o=1`; go to IDLE.
- Write stage is a one-deep pipeline register. It holds a valid bit, row, per-lane data, and per-lane mask. `w_en_o[i] = stage_valid & (row*lanes_p+i < vl)`.
- Ops, all modulo 2^`vdw_p`:
  - ADD: a+b.
  - SUB: a−b.
  - AND, OR, XOR: bitwise.
  - SLL, SRL: shift a by `b[clog2(vdw_p)-1:0]`; logical.
  - MUL: low `vdw_p` bits of a*b.
- Requests in non-IDLE states are not accepted; `v_i` is ignored while `ready_o=0`.
- `vl=0`: full timing runs with all `w_en_o` low; `done_o` still pulses.
- Aliasing (`vd` equal to `vs1` or `vs2`) is legal. Row r is written the cycle after it is read, and row r+1 is read in that same cycle, so no hazard exists.
- Latched selects are held from acceptance through DRAIN.

## Timing
- Reset values:
  - `ready_o=1`; `done_o=0`; `w_en_o=0`.
  - All addresses, write data, and select outputs are 0; FSM is IDLE; stage valid is 0.
- Accept at edge T. Row r is read during cycle T+1+r and written during cycle T+2+r.
- Final write and `done_o` occur in cycle T+1+`rows_lp`. `ready_o` returns in cycle T+2+`rows_lp`.
- Throughput: one op per `rows_lp+2` cycles.
- No back-to-back overlap; the new op is accepted in the cycle after DRAIN at the earliest.
- Reset mid-operation: the next cycle is IDLE with the stage cleared; no further writes; no `done_o`.
- Read addresses are registered state; read data is consumed in the same cycle.

## Structure
- `v_pkg` holds `typedef enum logic [2:0] {V_ADD, V_SUB, V_AND, V_OR, V_XOR, V_SLL, V_SRL, V_MUL} v_op_e` and the FSM state enum.
- Sub-module `v_lane_alu` (parameter `vdw_p`): combinational, one instance per lane. Inputs are op, a, b; output is result.
- Top level holds the FSM, row counter, latches, and write stage.

## Test plan
- Default parameters, ADD, `vl=8`, A[e]=e, B[e]=100: writes 100..107 on rows 0,1 in cycles T+2, T+3. `done_o` at T+3; `ready_o` high at T+4.
- SUB with A=0, B=1, every element: all writes are 0xFFFFFFFF (wrap). MUL with 0x10000 × 0x10000: writes 0.
- `vl=5`: row 0 `w_en_o=4'b1111`; row 1 `w_en_o=4'b0001`. `vl=0`: no enables, `done_o` still pulses at T+3.
- `vd=vs1`, ADD A+A with A[e]=e: final contents are 2e. Reads of row 1 see original values.
- Assert `reset_i` in the cycle after acceptance: no `w_en_o` and no `done_o` afterward; `ready_o=1` the following cycle.
- Hold `v_i=1` continuously: exactly one acceptance per 4-cycle window. Selects are stable across each op.

Source files
------------

// File: rtl/v_pkg.sv
// v_pkg: shared opcode and sequencer state encodings for the vector lane sequencer
package v_pkg;
  typedef enum logic [2:0] {V_ADD, V_SUB, V_AND, V_OR, V_XOR, V_SLL, V_SRL, V_MUL} v_op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} v_state_e;
endpackage

// File: rtl/v_lane_alu.sv
// v_lane_alu: combinational per-lane ALU, op_i selects f(a_i, b_i) -> y_o modulo 2^vdw_p
module v_lane_alu import v_pkg::*; #(
  parameter int vdw_p = 32
) (
  input  v_op_e            op_i,
  input  logic [vdw_p-1:0] a_i,
  input  logic [vdw_p-1:0] b_i,
  output logic [vdw_p-1:0] y_o
);
  localparam int sh_width_lp = $clog2(vdw_p);
  logic [sh_width_lp-1:0] sh;
  assign sh = b_i[sh_width_lp-1:0];
  always_comb
    y_o = op_i == V_ADD ? a_i + b_i :
          op_i == V_SUB ? a_i - b_i :
          op_i == V_AND ? a_i & b_i :
          op_i == V_OR  ? a_i | b_i :
          op_i == V_XOR ? a_i ^ b_i :
          op_i == V_SLL ? a_i << sh :
          op_i == V_SRL ? a_i >> sh :
                          a_i * b_i;
endmodule

// File: rtl/v_lane_sequencer.sv
// v_lane_sequencer: streams one element-wise vector op through banked register files, lanes_p elements per row; ports: v_i/ready_o request handshake, op/select/vl request fields, ra/rb read address+data, w_addr/w_data/w_en write port, done_o completion pulse
module v_lane_sequencer import v_pkg::*; #(
  parameter  int vlen_p        = 8,
  parameter  int vdw_p         = 32,
  parameter  int lanes_p       = 4,
  parameter  int vregs_p       = 8,
  localparam int addr_width_lp = $clog2(vlen_p),
  localparam int rows_lp       = vlen_p / lanes_p,
  localparam int vl_width_lp   = $clog2(vlen_p + 1),
  localparam int sel_width_lp  = $clog2(vregs_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   v_i,
  output logic                                   ready_o,
  input  logic [2:0]                             op_i,
  input  logic [sel_width_lp-1:0]                vs1_i,
  input  logic [sel_width_lp-1:0]                vs2_i,
  input  logic [sel_width_lp-1:0]                vd_i,
  input  logic [vl_width_lp-1:0]                 vl_i,
  output logic [sel_width_lp-1:0]                rs1_sel_o,
  output logic [sel_width_lp-1:0]                rs2_sel_o,
  output logic [sel_width_lp-1:0]                wd_sel_o,
  output logic [lanes_p-1:0][addr_width_lp-1:0]  ra_addr_o,
  output logic [lanes_p-1:0][addr_width_lp-1:0]  rb_addr_o,
  input  logic [lanes_p-1:0][vdw_p-1:0]          ra_data_i,
  input  logic [lanes_p-1:0][vdw_p-1:0]          rb_data_i,
  output logic [lanes_p-1:0][addr_width_lp-1:0]  w_addr_o,
  output logic [lanes_p-1:0][vdw_p-1:0]          w_data_o,
  output logic [lanes_p-1:0]                     w_en_o,
  output logic                                   done_o
);
  localparam int row_width_lp = rows_lp > 1 ? $clog2(rows_lp) : 1;
  v_state_e                              state_q, state_d;
  v_op_e                                 op_q;
  logic [sel_width_lp-1:0]               vs1_q, vs2_q, vd_q;
  logic [vl_width_lp-1:0]                vl_q;
  logic [row_width_lp-1:0]               row_q, row_d;
  logic [lanes_p-1:0][addr_width_lp-1:0] ra_q, ra_d, wa_q;
  logic [lanes_p-1:0][vdw_p-1:0]         alu_y, wd_q;
  logic [lanes_p-1:0]                    mask_d, mask_q;
  logic                                  stage_v_q, run, accept;
  always_comb begin
    run     = state_q == S_RUN;
    accept  = v_i & ready_o;
    state_d = state_q == S_IDLE ? (v_i ? S_RUN : S_IDLE) :
              run ? (row_q == row_width_lp'(rows_lp - 1) ? S_DRAIN : S_RUN) : S_IDLE;
    row_d   = run ? row_q + 1'b1 : '0;
    for (int i = 0; i < lanes_p; i++) begin
      ra_d[i]   = state_d == S_RUN ? addr_width_lp'(int'(row_d) * lanes_p + i) : '0;
      mask_d[i] = vl_width_lp'(ra_q[i]) < vl_q;
    end
  end
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state_q   <= S_IDLE;
      op_q      <= V_ADD;
      vs1_q     <= '0;
      vs2_q     <= '0;
      vd_q      <= '0;
      vl_q      <= '0;
      row_q     <= '0;
      ra_q      <= '0;
      wa_q      <= '0;
      wd_q      <= '0;
      mask_q    <= '0;
      stage_v_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      ra_q      <= ra_d;
      stage_v_q <= run;
      if (accept) begin
        op_q  <= v_op_e'(op_i);
        vs1_q <= vs1_i;
        vs2_q <= vs2_i;
        vd_q  <= vd_i;
        vl_q  <= vl_i;
      end
      if (run) begin
        wa_q   <= ra_q;
        wd_q   <= alu_y;
        mask_q <= mask_d;
      end
    end
  for (genvar i = 0; i < lanes_p; i++) begin : g_lane
    v_lane_alu #(.vdw_p(vdw_p)) u_alu (
      .op_i(op_q),
      .a_i (ra_data_i[i]),
      .b_i (rb_data_i[i]),
      .y_o (alu_y[i])
    );
  end
  assign ready_o   = state_q == S_IDLE;
  assign done_o    = state_q == S_DRAIN;
  assign rs1_sel_o = vs1_q;
  assign rs2_sel_o = vs2_q;
  assign wd_sel_o  = vd_q;
  assign ra_addr_o = ra_q;
  assign rb_addr_o = ra_q;
  assign w_addr_o  = wa_q;
  assign w_data_o  = wd_q;
  assign w_en_o    = mask_q & {lanes_p{stage_v_q}};
endmodule

// File: tb/tb_v_lane_sequencer.sv
// tb_v_lane_sequencer: directed and random ops against a vector-level reference model with emulated register files
module tb_v_lane_sequencer;
  localparam int VL = 8, DW = 32, LN = 4, NR = 8, ROWS = VL / LN;
  logic clk_i = 1'b0, reset_i = 1'b1, v_i = 1'b0;
  logic [2:0] op_i = '0, vs1_i = '0, vs2_i = '0, vd_i = '0;
  logic [3:0] vl_i = '0;
  logic ready_o, done_o;
  logic [2:0] rs1_sel_o, rs2_sel_o, wd_sel_o;
  logic [LN-1:0][2:0] ra_addr_o, rb_addr_o, w_addr_o;
  logic [LN-1:0][DW-1:0] ra_data_i, rb_data_i, w_data_o;
  logic [LN-1:0] w_en_o;
  logic [DW-1:0] rf [NR][VL];
  logic [DW-1:0] rf_init [NR][VL];
  logic load = 1'b0;
  int n_chk = 0, n_fail = 0;

  v_lane_sequencer dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o), .op_i(op_i),
    .vs1_i(vs1_i), .vs2_i(vs2_i), .vd_i(vd_i), .vl_i(vl_i),
    .rs1_sel_o(rs1_sel_o), .rs2_sel_o(rs2_sel_o), .wd_sel_o(wd_sel_o),
    .ra_addr_o(ra_addr_o), .rb_addr_o(rb_addr_o), .ra_data_i(ra_data_i), .rb_data_i(rb_data_i),
    .w_addr_o(w_addr_o), .w_data_o(w_data_o), .w_en_o(w_en_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb
    for (int i = 0; i < LN; i++) begin
      ra_data_i[i] = rf[rs1_sel_o][ra_addr_o[i]];
      rb_data_i[i] = rf[rs2_sel_o][rb_addr_o[i]];
    end

  always @(posedge clk_i)
    if (load) rf <= rf_init;
    else for (int i = 0; i < LN; i++) if (w_en_o[i]) rf[wd_sel_o][w_addr_o[i]] <= w_data_o[i];

  function automatic logic [DW-1:0] ref_op(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << (b % 32);
      6: return a >> (b % 32);
      default: return p[31:0];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_rf();
    load = 1'b1;
    @(posedge clk_i);
    #1 load = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ready_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    chk("ready_wait", ready_o, 1);
  endtask

  task automatic run_op(input int op, input int s1, input int s2, input int d, input int vl);
    logic [DW-1:0] exp [VL];
    logic [LN-1:0] en_exp;
    wait_ready();
    for (int e = 0; e < VL; e++) exp[e] = e < vl ? ref_op(op, rf[s1][e], rf[s2][e]) : rf[d][e];
    op_i = op[2:0]; vs1_i = s1[2:0]; vs2_i = s2[2:0]; vd_i = d[2:0]; vl_i = vl[3:0];
    v_i = 1'b1;
    @(posedge clk_i);
    #1 v_i = 1'b0;
    for (int k = 1; k <= ROWS + 2; k++) begin
      @(negedge clk_i);
      chk("ready", ready_o, k == ROWS + 2);
      chk("done", done_o, k == ROWS + 1);
      en_exp = '0;
      if (k >= 2 && k <= ROWS + 1) begin
        for (int i = 0; i < LN; i++) begin
          en_exp[i] = ((k - 2) * LN + i) < vl;
          chk("w_addr", w_addr_o[i], (k - 2) * LN + i);
        end
      end
      if (k <= ROWS)
        for (int i = 0; i < LN; i++) begin
          chk("ra_addr", ra_addr_o[i], (k - 1) * LN + i);
          chk("rb_addr", rb_addr_o[i], (k - 1) * LN + i);
        end
      chk("w_en", w_en_o, en_exp);
      chk("sels", {rs1_sel_o, rs2_sel_o, wd_sel_o}, {s1[2:0], s2[2:0], d[2:0]});
    end
    for (int e = 0; e < VL; e++) chk("rf", rf[d][e], exp[e]);
  endtask

  initial begin
    logic [DW-1:0] keep [VL];
    logic [8:0] acc_sel;
    int acc;
    for (int r = 0; r < NR; r++) for (int e = 0; e < VL; e++) rf_init[r][e] = $urandom;
    load = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 load = 1'b0;
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst_ready", ready_o, 1);
    chk("rst_done", done_o, 0);
    chk("rst_w_en", w_en_o, 0);
    chk("rst_ra_addr", ra_addr_o, 0);
    chk("rst_rb_addr", rb_addr_o, 0);
    chk("rst_w_addr", w_addr_o, 0);
    chk("rst_w_data", w_data_o[0] | w_data_o[1] | w_data_o[2] | w_data_o[3], 0);
    chk("rst_sels", {rs1_sel_o, rs2_sel_o, wd_sel_o}, 0);

    rf_init = rf;
    for (int e = 0; e < VL; e++) begin rf_init[1][e] = e; rf_init[2][e] = 100; end
    load_rf();
    run_op(0, 1, 2, 3, 8);
    chk("add_e7", rf[3][7], 107);

    rf_init = rf;
    for (int e = 0; e < VL; e++) begin rf_init[4][e] = 0; rf_init[5][e] = 1; end
    load_rf();
    run_op(1, 4, 5, 6, 8);
    chk("sub_wrap", rf[6][2], 32'hFFFF_FFFF);

    rf_init = rf;
    for (int e = 0; e < VL; e++) rf_init[4][e] = 32'h1_0000;
    load_rf();
    run_op(7, 4, 4, 6, 8);
    chk("mul_wrap", rf[6][3], 0);

    run_op(4, 2, 3, 5, 5);
    run_op(0, 1, 2, 7, 0);

    rf_init = rf;
    for (int e = 0; e < VL; e++) rf_init[1][e] = e;
    load_rf();
    run_op(0, 1, 1, 1, 8);
    chk("alias_e7", rf[1][7], 14);

    for (int n = 0; n < 24; n++) begin
      if (n % 4 == 0) begin
        for (int r = 0; r < NR; r++) for (int e = 0; e < VL; e++) rf_init[r][e] = $urandom;
        load_rf();
      end
      run_op($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 8));
    end

    wait_ready();
    for (int e = 0; e < VL; e++) keep[e] = rf[6][e];
    op_i = 3'd0; vs1_i = 3'd1; vs2_i = 3'd2; vd_i = 3'd6; vl_i = 4'd8;
    v_i = 1'b1;
    @(posedge clk_i);
    #1 v_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    chk("rst_mid_ready", ready_o, 1);
    for (int k = 0; k < 4; k++) begin
      chk("rst_mid_w_en", w_en_o, 0);
      chk("rst_mid_done", done_o, 0);
      @(negedge clk_i);
    end
    for (int e = 0; e < VL; e++) chk("rst_mid_rf", rf[6][e], keep[e]);

    acc = 0;
    acc_sel = '0;
    v_i = 1'b1;
    vl_i = 4'd8;
    for (int c = 0; c < 12; c++) begin
      op_i = 3'($urandom_range(0, 7));
      vs1_i = 3'($urandom_range(0, 7));
      vs2_i = 3'($urandom_range(0, 7));
      vd_i = 3'($urandom_range(0, 7));
      chk("hold_ready", ready_o, c % 4 == 0);
      if (ready_o) begin
        acc++;
        acc_sel = {vs1_i, vs2_i, vd_i};
      end else chk("hold_sels", {rs1_sel_o, rs2_sel_o, wd_sel_o}, acc_sel);
      @(negedge clk_i);
    end
    v_i = 1'b0;
    chk("hold_accepts", acc, 3);
    wait_ready();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
